// File: rtl/sv_uart_pkg.sv
// ---------------------------------------------------------------------------
// sv_uart_pkg
// Shared definitions for the UART core: character width, stop-bit count and
// the state type of the receive-side word packer.
// ---------------------------------------------------------------------------
package sv_uart_pkg;

    // Bits per UART character; the packer assembles words from these.
    localparam int WORD_WIDTH = 8;

    // Stop bits framed around each character by the UART engine.
    localparam int STOP_BITS  = 1;

    // Receive packer collect FSM: IDLE holds no partial word, COLLECT does.
    typedef enum logic {
        RX_IDLE,
        RX_COLLECT
    } rx_pack_state_t;

    // Number of characters that make up one DATA_WIDTH-bit word.
    function automatic int words_num(input int data_width);
        return data_width / WORD_WIDTH;
    endfunction

endpackage

// File: rtl/sv_uart_rx_timer.sv
// ---------------------------------------------------------------------------
// sv_uart_rx_timer
// Inter-byte timeout for the receive packer. Counts idle cycles while a
// partial word is held and flags when the partial word must be dropped.
//
// Ports:
//   iclk, irst_n  clock, asynchronous active-low reset
//   byte_accept   a byte is accepted this cycle (restarts the count)
//   word_idle     no partial word held (count held at zero)
//   itimeout      timeout in iclk cycles, 0 disables
//   expire        combinational: discard the partial word at this edge
//   otimeout      registered one-cycle pulse, the cycle after expire
// ---------------------------------------------------------------------------
module sv_uart_rx_timer (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        byte_accept,
    input  logic        word_idle,
    input  logic [15:0] itimeout,
    output logic        expire,
    output logic        otimeout
);

    logic [15:0] tcnt_q, tcnt_d;
    logic        otimeout_q, otimeout_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        tcnt_d     = tcnt_q;
        otimeout_d = 1'b0;

        // Compare in 17 bits so a saturated count can never alias to a match.
        // An accept in the same cycle always wins over the timeout.
        expire = (itimeout != 16'd0)
              && (({1'b0, tcnt_q} + 17'd1) == {1'b0, itimeout})
              && !byte_accept
              && !word_idle;

        if (byte_accept || word_idle || expire) begin
            tcnt_d = 16'd0;
        end else if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
        end

        otimeout_d = expire;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            tcnt_q     <= 16'd0;
            otimeout_q <= 1'b0;
        end else begin
            tcnt_q     <= tcnt_d;
            otimeout_q <= otimeout_d;
        end
    end

    assign otimeout = otimeout_q;

endmodule

// File: rtl/sv_uart_rx_packer.sv
// ---------------------------------------------------------------------------
// sv_uart_rx_packer
// Receive-side word assembler. Collects WORDS_NUM consecutive bytes from the
// UART byte receiver into one DATA_WIDTH-bit AXI-Stream word, first byte in
// the most significant position (mirrors the MSB-first transmit path).
// A partial word that sees no new byte for itimeout cycles is discarded so a
// lost byte cannot misalign framing forever; a complete word is never lost.
//
// Ports:
//   iclk, irst_n   clock, asynchronous active-low reset
//   s_axis_*       8-bit byte stream from the UART receiver
//   m_axis_*       DATA_WIDTH-bit word stream towards the user
//   itimeout       inter-byte timeout in iclk cycles, 0 disables
//   otimeout       one-cycle pulse when a partial word is discarded
// ---------------------------------------------------------------------------
module sv_uart_rx_packer
    import sv_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  iclk,
    input  logic                  irst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [15:0]           itimeout,
    output logic                  otimeout
);

    localparam int WORDS_NUM = words_num(DATA_WIDTH);
    localparam int ACC_W     = DATA_WIDTH - WORD_WIDTH;
    localparam int CNT_W     = $clog2(WORDS_NUM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_NUM - 1);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16) begin : g_bad_width
            $error("sv_uart_rx_packer: DATA_WIDTH must be a multiple of 8 and at least 16");
        end
    endgenerate

    rx_pack_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH-1:0] obuf_q, obuf_d;
    logic                  ofull_q, ofull_d;

    logic                  last_byte;
    logic                  byte_accept;
    logic                  expire;
    logic [ACC_W-1:0]      acc_shift;

    assign last_byte = (cnt_q == LAST_CNT);

    // Only the final byte of a word can stall, and only while the previous
    // word is still held downstream. This is the sole combinational path
    // from m_axis_tready.
    assign s_axis_tready = !(last_byte && ofull_q && !m_axis_tready);
    assign byte_accept   = s_axis_tvalid && s_axis_tready;

    // With a single accumulated byte there is nothing to shift out.
    generate
        if (ACC_W == WORD_WIDTH) begin : g_acc_single
            assign acc_shift = s_axis_tdata;
        end else begin : g_acc_shift
            assign acc_shift = {acc_q[ACC_W-WORD_WIDTH-1:0], s_axis_tdata};
        end
    endgenerate

    sv_uart_rx_timer u_timer (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .byte_accept (byte_accept),
        .word_idle   (state_q == RX_IDLE),
        .itimeout    (itimeout),
        .expire      (expire),
        .otimeout    (otimeout)
    );

    // Collect FSM plus output register next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        obuf_d  = obuf_q;
        ofull_d = ofull_q;

        // Downstream handshake frees the output; a word completing in the
        // same cycle sets it again below.
        if (ofull_q && m_axis_tready) begin
            ofull_d = 1'b0;
        end

        case (state_q)
            RX_IDLE: begin
                // WORDS_NUM >= 2, so the first byte is never the final one.
                if (byte_accept) begin
                    acc_d   = acc_shift;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RX_COLLECT;
                end
            end
            RX_COLLECT: begin
                if (byte_accept) begin
                    if (last_byte) begin
                        obuf_d  = {acc_q, s_axis_tdata};
                        ofull_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = RX_IDLE;
                    end else begin
                        acc_d   = acc_shift;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else if (expire) begin
                    // Drop only the partial word; obuf/ofull are untouched.
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            obuf_q  <= '0;
            ofull_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            obuf_q  <= obuf_d;
            ofull_q <= ofull_d;
        end
    end

    assign m_axis_tdata  = obuf_q;
    assign m_axis_tvalid = ofull_q;

endmodule
